// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: shared op/state encodings, CSR addresses and default width
package csr_trap_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } op_e;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
endpackage

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: pipeline request/response and CSR-file access signals
interface csr_trap_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [11:0]           in_csr_addr;
    logic [DATA_WIDTH-1:0] in_operand;
    logic                  in_src_zero;
    logic [DATA_WIDTH-1:0] in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_rd_we;
    logic [DATA_WIDTH-1:0] out_rd_wdata;
    logic                  out_redirect;
    logic [DATA_WIDTH-1:0] out_redirect_pc;
    logic                  csr_en;
    logic [11:0]           csr_id;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic [DATA_WIDTH-1:0] csr_rdata;
    logic                  csr_ecall;
    logic [DATA_WIDTH-1:0] csr_pc;
    logic [DATA_WIDTH-1:0] csr_mtvec;
    logic [DATA_WIDTH-1:0] csr_mepc;
    modport master (
        input  in_valid, in_op, in_csr_addr, in_operand, in_src_zero, in_pc, out_ready,
               csr_rdata, csr_mtvec, csr_mepc,
        output in_ready, out_valid, out_rd_we, out_rd_wdata, out_redirect, out_redirect_pc,
               csr_en, csr_id, csr_wdata, csr_ecall, csr_pc
    );
    modport slave (
        output in_valid, in_op, in_csr_addr, in_operand, in_src_zero, in_pc, out_ready,
               csr_rdata, csr_mtvec, csr_mepc,
        input  in_ready, out_valid, out_rd_we, out_rd_wdata, out_redirect, out_redirect_pc,
               csr_en, csr_id, csr_wdata, csr_ecall, csr_pc
    );
endinterface

// File: rtl/csr_trap_ctrl_alu.sv
// csr_trap_ctrl_alu: combinational CSRRW/CSRRS/CSRRC new-value computation
module csr_trap_ctrl_alu
    import csr_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    output logic [DATA_WIDTH-1:0] new_o
);
    // non-CSR ops pass the old value through untouched
    always_comb begin
        new_o = op_i == OP_CSRRW ? operand_i :
                op_i == OP_CSRRS ? (old_i | operand_i) :
                op_i == OP_CSRRC ? (old_i & ~operand_i) : old_i;
    end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: CSR/trap sequencer, IDLE->READ->WRITE->RESP; CSR_SKIP_ZERO_WRITE_EN suppresses CSRRS/CSRRC writes with zero source
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic          clk,
    input logic          rst,
    csr_trap_ctrl_if.master bus
);
    state_e                state_q, state_d;
    logic [2:0]            op_q;
    logic [11:0]           addr_q;
    logic [DATA_WIDTH-1:0] opnd_q, pc_q, old_q, new_q, tgt_q, alu_new;
    logic                  sz_q, is_csr, is_trap, do_wr, wr, rsp;

    csr_trap_ctrl_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i      (op_q),
        .old_i     (bus.csr_rdata),
        .operand_i (opnd_q),
        .new_o     (alu_new)
    );

    assign is_csr  = op_q inside {OP_CSRRW, OP_CSRRS, OP_CSRRC};
    assign is_trap = op_q inside {OP_ECALL, OP_MRET};
`ifdef CSR_SKIP_ZERO_WRITE_EN
    assign do_wr = is_csr && !(sz_q && op_q != OP_CSRRW);
`else
    logic unused_sz;
    assign unused_sz = sz_q;
    assign do_wr     = is_csr;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state: one cycle each in READ and WRITE, hold RESP until accepted
    always_comb begin
        state_d = state_q == IDLE  ? (bus.in_valid ? READ : IDLE) :
                  state_q == READ  ? WRITE :
                  state_q == WRITE ? RESP :
                  (bus.out_ready ? IDLE : RESP);
    end

    // request capture in IDLE, old value / new value / trap target latched in READ
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            addr_q <= '0;
            opnd_q <= '0;
            sz_q   <= 1'b0;
            pc_q   <= '0;
            old_q  <= '0;
            new_q  <= '0;
            tgt_q  <= '0;
        end else if (state_q == IDLE && bus.in_valid) begin
            op_q   <= bus.in_op;
            addr_q <= bus.in_csr_addr;
            opnd_q <= bus.in_operand;
            sz_q   <= bus.in_src_zero;
            pc_q   <= bus.in_pc;
        end else if (state_q == READ) begin
            old_q <= bus.csr_rdata;
            new_q <= alu_new;
            tgt_q <= op_q == OP_ECALL ? bus.csr_mtvec :
                     op_q == OP_MRET  ? bus.csr_mepc : '0;
        end
    end

    // outputs decoded from state; strobes are masked by rst so a reset in WRITE commits nothing
    always_comb begin
        wr                  = state_q == WRITE && !rst;
        rsp                 = state_q == RESP;
        bus.in_ready        = state_q == IDLE;
        bus.csr_id          = addr_q;
        bus.csr_en          = wr && do_wr;
        bus.csr_wdata       = wr && do_wr ? new_q : '0;
        bus.csr_ecall       = wr && op_q == OP_ECALL;
        bus.csr_pc          = wr && op_q == OP_ECALL ? pc_q : '0;
        bus.out_valid       = rsp;
        bus.out_rd_we       = rsp && is_csr;
        bus.out_rd_wdata    = rsp && is_csr ? old_q : '0;
        bus.out_redirect    = rsp && is_trap;
        bus.out_redirect_pc = rsp && is_trap ? tgt_q : '0;
    end
endmodule
